// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared definitions for the write-back stage.
//   - bus widths for the memory->WB input bus and the two WB output buses
//   - the simulation trap encoding
//   - FSM state encoding (RUN / HALTED)
//   - stall vector bit indices
//   - packed views of the incoming bus and of a register write request
package wb_stage_pkg;

  localparam int MEM2WB_WD = 166;
  localparam int WB2RF_WD  = 70;
  localparam int WB2EX_WD  = 70;

  localparam logic [31:0] TRAP_INST = 32'h0000_006b;

  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } wb_state_e;

  // Field order matches the flat bus: {rf_we, rf_waddr, rf_wdata, pc, inst}
  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [63:0] pc;
    logic [31:0] inst;
  } mem2wb_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
  } wb_wr_t;

  function automatic logic is_trap(input logic [31:0] inst);
    return inst == TRAP_INST;
  endfunction

endpackage

// File: rtl/wb_commit_ctr.sv
// wb_commit_ctr: commit decision, halt FSM and the cycle / retired-instruction
// counters of the write-back stage.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   valid_i        the instruction held in the WB register is not a bubble
//   stall_wb_i     WB stage stalled this cycle
//   trap_i         the held instruction is the simulation trap
//   rf_a0_i        current value of x10 (exit code source)
//   commit_o       the held instruction retires this cycle
//   halt_o         core halted
//   halt_stall_o   stall request to the pipeline controller
//   good_trap_o    halted with a zero exit code
//   exit_code_o    x10 captured at the trap
//   cycle_cnt_o    cycles since reset, frozen once halted
//   instret_cnt_o  retired instructions
//
// State table:
//   state  | meaning
//   RUN    | normal operation, instructions may commit
//   HALTED | trap retired; terminal until reset, no further commits
module wb_commit_ctr
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        stall_wb_i,
  input  logic        trap_i,
  input  logic [63:0] rf_a0_i,
  output logic        commit_o,
  output logic        halt_o,
  output logic        halt_stall_o,
  output logic        good_trap_o,
  output logic [63:0] exit_code_o,
  output logic [63:0] cycle_cnt_o,
  output logic [63:0] instret_cnt_o
);

  wb_state_e   state_q, state_d;
  logic [63:0] cycle_q, cycle_d;
  logic [63:0] instret_q, instret_d;
  logic [63:0] exit_q, exit_d;
  logic        good_q, good_d;
  logic        commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      cycle_q   <= '0;
      instret_q <= '0;
      exit_q    <= '0;
      good_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      exit_q    <= exit_d;
      good_q    <= good_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cycle_d   = cycle_q;
    instret_d = instret_q;
    exit_d    = exit_q;
    good_d    = good_q;
    commit    = 1'b0;

    case (state_q)
      RUN: begin
        cycle_d = cycle_q + 64'd1;
        // A stalled instruction stays in the register and retires on the
        // first unstalled cycle, so it is counted exactly once.
        commit  = valid_i && !stall_wb_i;
        if (commit) begin
          instret_d = instret_q + 64'd1;
          if (trap_i) begin
            state_d = HALTED;
            exit_d  = rf_a0_i;
            good_d  = (rf_a0_i == 64'd0);
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign commit_o      = commit;
  assign halt_o        = (state_q == HALTED);
  assign halt_stall_o  = (state_q == HALTED);
  assign good_trap_o   = good_q;
  assign exit_code_o   = exit_q;
  assign cycle_cnt_o   = cycle_q;
  assign instret_cnt_o = instret_q;

endmodule

// File: rtl/wb_stage.sv
// wb_stage: final pipeline stage. Registers the memory-stage result under the
// stall vector, drives the register-file write port and the WB->EX forwarding
// path, counts cycles / retired instructions and halts on the trap
// instruction.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   stall        stall vector (bit 4 = MEM, bit 5 = WB)
//   mem2wb_bus   {rf_we, rf_waddr, rf_wdata, pc, inst} from MEM
//   rf_a0        current x10, captured as exit code at the trap
//   wb2rf_bus    {we, waddr, wdata} register-file write request
//   wb2ex_fwd    {we, waddr, wdata} forwarding to EX, driven even when stalled
//   halt         core halted
//   halt_stall   stall request while halted
//   good_trap    halted with rf_a0 == 0
//   exit_code    rf_a0 at the trap
//   cycle_cnt    cycles since reset
//   instret_cnt  retired instructions
//
// Optional build macro DIFFTEST_EN adds commit_valid, commit_pc, commit_inst,
// commit_wen, commit_wdest, commit_wdata and commit_trap, all registered one
// cycle after the commit they describe.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int MEM2WB_W = MEM2WB_WD,
  parameter int WB2RF_W  = WB2RF_WD,
  parameter int WB2EX_W  = WB2EX_WD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  input  logic [MEM2WB_W-1:0] mem2wb_bus,
  input  logic [63:0]         rf_a0,
  output logic [WB2RF_W-1:0]  wb2rf_bus,
  output logic [WB2EX_W-1:0]  wb2ex_fwd,
  output logic                halt,
  output logic                halt_stall,
  output logic                good_trap,
  output logic [63:0]         exit_code,
  output logic [63:0]         cycle_cnt,
  output logic [63:0]         instret_cnt
`ifdef DIFFTEST_EN
  ,
  output logic                commit_valid,
  output logic [63:0]         commit_pc,
  output logic [31:0]         commit_inst,
  output logic                commit_wen,
  output logic [4:0]          commit_wdest,
  output logic [63:0]         commit_wdata,
  output logic                commit_trap
`endif
);

  mem2wb_t wb_r_q, wb_r_d;
  wb_wr_t  rf_wr, fwd_wr;
  logic    valid;
  logic    dest_ok;
  logic    commit;
  logic    trap;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_r_q <= '0;
    end else begin
      wb_r_q <= wb_r_d;
    end
  end

  // MEM stalled but WB free: MEM has nothing new to hand over, so insert a
  // bubble rather than re-present the instruction that is committing now.
  always_comb begin
    wb_r_d = wb_r_q;
    if (!stall[STALL_MEM]) begin
      wb_r_d = mem2wb_t'(mem2wb_bus);
    end else if (!stall[STALL_WB]) begin
      wb_r_d = '0;
    end
  end

  assign valid   = (wb_r_q.inst != 32'd0);
  assign dest_ok = wb_r_q.rf_we && (wb_r_q.rf_waddr != 5'd0);
  assign trap    = is_trap(wb_r_q.inst);

  wb_commit_ctr u_commit_ctr (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid),
    .stall_wb_i    (stall[STALL_WB]),
    .trap_i        (trap),
    .rf_a0_i       (rf_a0),
    .commit_o      (commit),
    .halt_o        (halt),
    .halt_stall_o  (halt_stall),
    .good_trap_o   (good_trap),
    .exit_code_o   (exit_code),
    .cycle_cnt_o   (cycle_cnt),
    .instret_cnt_o (instret_cnt)
  );

  always_comb begin
    rf_wr.we     = commit && dest_ok;
    rf_wr.waddr  = wb_r_q.rf_waddr;
    rf_wr.wdata  = wb_r_q.rf_wdata;
    // Forwarding ignores stall/halt: EX only needs the youngest value in flight.
    fwd_wr.we    = valid && dest_ok;
    fwd_wr.waddr = wb_r_q.rf_waddr;
    fwd_wr.wdata = wb_r_q.rf_wdata;
  end

  assign wb2rf_bus = rf_wr;
  assign wb2ex_fwd = fwd_wr;

`ifdef DIFFTEST_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      commit_inst  <= '0;
      commit_wen   <= 1'b0;
      commit_wdest <= '0;
      commit_wdata <= '0;
      commit_trap  <= 1'b0;
    end else begin
      commit_valid <= commit;
      commit_pc    <= wb_r_q.pc;
      commit_inst  <= wb_r_q.inst;
      commit_wen   <= rf_wr.we;
      commit_wdest <= wb_r_q.rf_waddr;
      commit_wdata <= wb_r_q.rf_wdata;
      commit_trap  <= commit && trap;
    end
  end

  logic unused_stall;
  assign unused_stall = ^stall[3:0];
`else
  logic unused_bits;
  assign unused_bits = ^{stall[3:0], wb_r_q.pc};
`endif

endmodule
